// File: rtl/id_banco_registros.sv
// 32x32 register file for the ID stage. Operand reads are combinational with a write-through bypass.
// A dump FSM streams every register over a valid/ready handshake and holds its word while ready is low.
module id_banco_registros #(
   parameter int NBITS     = 32,
   parameter int NREG      = 32,
   parameter int NBITS_REG = 5
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_RegWrite,
   input  logic [NBITS_REG-1:0] i_DirEscritura,
   input  logic [NBITS-1:0]     i_DatoEscritura,
   input  logic [NBITS_REG-1:0] i_DirLecturaA,
   input  logic [NBITS_REG-1:0] i_DirLecturaB,
   output logic [NBITS-1:0]     o_DatoA,
   output logic [NBITS-1:0]     o_DatoB,
   input  logic                 i_DumpStart,
   input  logic                 i_DumpReady,
   output logic [NBITS-1:0]     o_DumpDato,
   output logic [NBITS_REG-1:0] o_DumpDir,
   output logic                 o_DumpValid,
   output logic                 o_DumpBusy,
   output logic                 o_DumpDone
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } dump_state_e;

   localparam logic [NBITS_REG-1:0] LAST_IDX = NBITS_REG'(NREG - 1);

   logic [NBITS-1:0]     regs_q [NREG];
   dump_state_e          state_q, state_d;
   logic [NBITS_REG-1:0] idx_q, idx_d;
   logic                 wr_en;

   // r0 is never written, so it stays at its reset value of zero.
   assign wr_en = i_RegWrite && (i_DirEscritura != '0);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[i_DirEscritura] <= i_DatoEscritura;
      end
   end

   // Bypass lets ID see a WB result in the same cycle it is written.
   always_comb begin
      o_DatoA = regs_q[i_DirLecturaA];
      o_DatoB = regs_q[i_DirLecturaB];
      if (wr_en && (i_DirEscritura == i_DirLecturaA)) begin
         o_DatoA = i_DatoEscritura;
      end
      if (wr_en && (i_DirEscritura == i_DirLecturaB)) begin
         o_DatoB = i_DatoEscritura;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      o_DumpDato  = '0;
      o_DumpDir   = '0;
      o_DumpValid = 1'b0;
      o_DumpBusy  = 1'b0;
      o_DumpDone  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_DumpStart) begin
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            // Dump reads committed state only; no bypass from the WB port.
            o_DumpValid = 1'b1;
            o_DumpBusy  = 1'b1;
            o_DumpDir   = idx_q;
            o_DumpDato  = regs_q[idx_q];
            if (i_DumpReady) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + NBITS_REG'(1);
               end
            end
         end
         DONE: begin
            o_DumpBusy = 1'b1;
            o_DumpDone = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_id_banco_registros.sv
// Bench for id_banco_registros: table-driven operand vectors plus scoreboarded dump sequences.
module tb_id_banco_registros;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reg_write;
   logic [4:0]  dir_esc;
   logic [31:0] dato_esc;
   logic [4:0]  dir_a, dir_b;
   logic [31:0] dato_a, dato_b;
   logic        dump_start, dump_ready;
   logic [31:0] dump_dato;
   logic [4:0]  dump_dir;
   logic        dump_valid, dump_busy, dump_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_banco_registros #(.NBITS(32), .NREG(32), .NBITS_REG(5)) dut (
      .i_clk          (clk),
      .i_reset        (rst_n),
      .i_RegWrite     (reg_write),
      .i_DirEscritura (dir_esc),
      .i_DatoEscritura(dato_esc),
      .i_DirLecturaA  (dir_a),
      .i_DirLecturaB  (dir_b),
      .o_DatoA        (dato_a),
      .o_DatoB        (dato_b),
      .i_DumpStart    (dump_start),
      .i_DumpReady    (dump_ready),
      .o_DumpDato     (dump_dato),
      .o_DumpDir      (dump_dir),
      .o_DumpValid    (dump_valid),
      .o_DumpBusy     (dump_busy),
      .o_DumpDone     (dump_done)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   typedef struct {
      logic [4:0]  dir;
      logic [31:0] dato;
   } dexp_t;

   vec_t  vecs[11];
   dexp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      reg_write = 1'b1;
      dir_esc   = a;
      dato_esc  = d;
      step();
      reg_write = 1'b0;
   endtask

   task automatic push_dump(input int mult);
      for (int i = 0; i < 32; i++) begin
         dexp_t e;
         e.dir  = 5'(i);
         e.dato = 32'(i * mult);
         sb.push_back(e);
      end
   endtask

   // mode 0: ready held high; mode 1: ready alternates and extra start pulses arrive mid-dump.
   task automatic run_dump(input int mode, input string tag);
      int    beats    = 0;
      int    done_cnt = 0;
      int    done_p   = -1;
      bit    held     = 1'b0;
      logic [4:0] prev_dir = '0;
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      for (int p = 1; p <= 200; p++) begin
         dump_ready = (mode == 0) ? 1'b1 : logic'(p % 2 == 0);
         dump_start = (mode == 1) && (p == 5 || p == 20 || p == 41);
         #3;
         if (p == 1) chk({tag, "_first_valid"}, 32'(dump_valid), 32'd1);
         if (dump_valid) begin
            if (held) chk({tag, "_dir_hold"}, 32'(dump_dir), 32'(prev_dir));
            if (dump_ready) begin
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL %s_extra_beat: got dir %0d expected none", tag, dump_dir);
               end else begin
                  dexp_t e = sb.pop_front();
                  chk({tag, "_dir"}, 32'(dump_dir), 32'(e.dir));
                  chk({tag, "_dato"}, dump_dato, e.dato);
                  beats++;
               end
            end
            held     = !dump_ready;
            prev_dir = dump_dir;
         end
         if (dump_done) begin
            done_cnt++;
            done_p = p;
         end
         if (done_p > 0 && p == done_p + 1) begin
            chk({tag, "_idle_after_done"}, 32'(dump_busy), 32'd0);
            break;
         end
         step();
      end
      dump_start = 1'b0;
      dump_ready = 1'b0;
      chk({tag, "_beats"}, 32'(beats), 32'd32);
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      if (mode == 0) chk({tag, "_done_cycle"}, 32'(done_p), 32'd33);
      sb.delete();
      step();
   endtask

   initial begin
      int found;
      rst_n      = 1'b0;
      reg_write  = 1'b0;
      dir_esc    = '0;
      dato_esc   = '0;
      dir_a      = 5'd3;
      dir_b      = 5'd31;
      dump_start = 1'b0;
      dump_ready = 1'b0;

      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd0,  32'h0,        32'h0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
      vecs[4]  = '{1'b1, 5'd7,  32'h00000055, 5'd7,  5'd7,  32'h55,       32'h55};
      vecs[5]  = '{1'b0, 5'd7,  32'h00000077, 5'd7,  5'd7,  32'h55,       32'h55};
      vecs[6]  = '{1'b1, 5'd7,  32'h00000066, 5'd7,  5'd5,  32'h66,       32'hDEADBEEF};
      vecs[7]  = '{1'b1, 5'd9,  32'h0000A5A5, 5'd7,  5'd9,  32'h66,       32'hA5A5};
      vecs[8]  = '{1'b0, 5'd9,  32'h0,        5'd9,  5'd31, 32'hA5A5,     32'h0};
      vecs[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
      vecs[10] = '{1'b0, 5'd31, 32'h0,        5'd0,  5'd31, 32'h0,        32'hFFFFFFFF};

      #3;
      chk("reset_dato_a", dato_a, 32'h0);
      chk("reset_valid", 32'(dump_valid), 32'd0);
      chk("reset_busy", 32'(dump_busy), 32'd0);
      chk("reset_done", 32'(dump_done), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         reg_write = vecs[i].we;
         dir_esc   = vecs[i].wa;
         dato_esc  = vecs[i].wd;
         dir_a     = vecs[i].ra;
         dir_b     = vecs[i].rb;
         #3;
         chk($sformatf("vec%0d_a", i), dato_a, vecs[i].exp_a);
         chk($sformatf("vec%0d_b", i), dato_b, vecs[i].exp_b);
         step();
      end
      reg_write = 1'b0;

      // Asynchronous reset between edges clears a freshly written register.
      wr(5'd3, 32'h11);
      dir_a = 5'd3;
      #2;
      chk("r3_loaded", dato_a, 32'h11);
      rst_n = 1'b0;
      #1;
      chk("async_reset_r3", dato_a, 32'h0);
      chk("async_reset_valid", 32'(dump_valid), 32'd0);
      chk("async_reset_busy", 32'(dump_busy), 32'd0);
      for (int i = 0; i < 32; i++) begin
         dir_a = 5'(i);
         dir_b = 5'(31 - i);
         #1;
         chk($sformatf("reset_zero_a%0d", i), dato_a, 32'h0);
         chk($sformatf("reset_zero_b%0d", 31 - i), dato_b, 32'h0);
      end
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 32; i++) wr(5'(i), 32'(i * 4));
      push_dump(4);
      run_dump(0, "full");
      push_dump(4);
      run_dump(1, "bp");

      // Abort: reset once index 10 is on the dump port.
      found = 0;
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      dump_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         #3;
         if (dump_valid && dump_dir == 5'd10) begin
            found = 1;
            break;
         end
         step();
      end
      chk("abort_reached_idx10", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(dump_valid), 32'd0);
      chk("abort_busy", 32'(dump_busy), 32'd0);
      chk("abort_done", 32'(dump_done), 32'd0);
      step();
      rst_n = 1'b1;
      found = 0;
      for (int p = 0; p < 5; p++) begin
         #3;
         if (dump_done || dump_busy) found++;
         step();
      end
      chk("abort_no_done_after", 32'(found), 32'd0);
      dump_ready = 1'b0;
      push_dump(0);
      run_dump(0, "restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_banco_registros.md
Name: id_banco_registros

Overview:
- 32x32 MIPS register file in the ID stage; write end of the write-back path.
- Accepts the selected write-back word (memory/ALU data or PC+8 on JAL) plus destination and enable from WB.
- Supplies rs/rt operands to ID.
- Embeds a dump FSM that streams all registers to the debug unit over a valid/ready handshake.

Parameters:
- NBITS, 32, data word width.
- NREG, 32, number of architectural registers.
- NBITS_REG, 5, register address width (log2 NREG).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_RegWrite  in  1  write enable from WB.
- i_DirEscritura  in  NBITS_REG  destination register from WB.
- i_DatoEscritura  in  NBITS  write-back data from WB.
- i_DirLecturaA  in  NBITS_REG  rs address.
- i_DirLecturaB  in  NBITS_REG  rt address.
- o_DatoA  out  NBITS  rs operand.
- o_DatoB  out  NBITS  rt operand.
- i_DumpStart  in  1  debug unit dump request (level sampled).
- i_DumpReady  in  1  debug unit accepts current dump word.
- o_DumpDato  out  NBITS  register contents being dumped.
- o_DumpDir  out  NBITS_REG  index of register being dumped.
- o_DumpValid  out  1  dump word valid.
- o_DumpBusy  out  1  dump in progress.
- o_DumpDone  out  1  one-cycle pulse after last word accepted.

Behaviour:
- Reset (i_reset=0, asynchronous, takes effect without a clock edge):
  - all registers = 0.
  - FSM = IDLE, dump index = 0.
  - o_DumpValid/o_DumpBusy/o_DumpDone = 0.
  - o_DatoA/o_DatoB read 0 for any address.
- Write:
  - At posedge i_clk, if i_RegWrite=1 and i_DirEscritura!=0, then reg[i_DirEscritura] <= i_DatoEscritura.
  - Writes to r0 are discarded; r0 always reads 0.
- Read: combinational, zero latency.
  - Write-through bypass: if i_RegWrite=1, i_DirEscritura==i_DirLecturaX, and address !=0, then o_DatoX = i_DatoEscritura in that same cycle.
  - Otherwise o_DatoX = stored reg[i_DirLecturaX].
  - Port A and port B bypass independently; both may bypass the same write.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: o_DumpBusy=0, o_DumpValid=0. When i_DumpStart=1 at a clock edge: index <= 0, go to SEND.
  - SEND:
    - o_DumpBusy=1, o_DumpValid=1, o_DumpDir=index.
    - o_DumpDato = stored reg[index], no bypass; reflects writes already committed.
    - Transfer happens on a clock edge where i_DumpReady=1.
    - On transfer with index==NREG-1, go to DONE; otherwise index <= index+1.
    - While i_DumpReady=0, index, o_DumpDir and FSM state are held. o_DumpDato follows stored contents only if the pipeline writes that register.
  - DONE: o_DumpDone=1 and o_DumpBusy=1 for exactly one cycle, then go to IDLE.
  - i_DumpStart is ignored in SEND and DONE. If still high when back in IDLE, a new dump starts on the next edge.
- Dump outputs when not in SEND: o_DumpDato=0 and o_DumpDir=0.
- Dump timing: start sampled at edge N; first valid word at cycle N+1. With i_DumpReady held 1, words occupy cycles N+1..N+32 and o_DumpDone pulses in cycle N+33.
- Pipeline writes are allowed during a dump. A register is dumped with the value stored at its transfer edge.
- Reset asserted mid-dump aborts immediately. No o_DumpDone pulse is produced; the next start begins at index 0.
- Index counter is NBITS_REG wide; it never wraps because the FSM leaves SEND at NREG-1.

Test Plan:
- Reset: drive i_reset=0 between clock edges after loading r3=0x11 -> o_DatoA (addr 3)=0 immediately; o_DumpValid=0, o_DumpBusy=0; all 32 addresses read 0.
- Write/read: write r5=0xDEADBEEF, next cycle A=5 -> 0xDEADBEEF; write r0=0x1234 with RegWrite=1 -> reading r0 gives 0x00000000.
- Bypass: RegWrite=1, DirEscritura=7, Dato=0x00000055, A=B=7 in the same cycle -> o_DatoA=o_DatoB=0x55 before the edge; with RegWrite=0 -> old r7 value.
- Full dump: preload r_i=i*4, pulse i_DumpStart at edge N, i_DumpReady=1 -> 32 beats, Dir 0..31, Dato 0,4,...,124 (r0=0), o_DumpDone high only in cycle N+33.
- Backpressure: i_DumpReady alternating 0/1 plus extra i_DumpStart pulses mid-dump -> no skipped or duplicated Dir, Dir stable while Ready=0, exactly one Done pulse, extra starts ignored.
- Abort: reset at index 10 mid-dump -> Valid/Busy drop asynchronously, no Done; next start -> first Dir=0.
